// File: rtl/emergency_phase_sequencer_if.sv
// Lamp-side bundle of the emergency phase sequencer: timebase, requests, hold length, normal greens and all lamp/status outputs.
// Latency: none, wires only.
// Backpressure: none; the sequencer consumes every input on every clock.
interface emergency_phase_sequencer_if #(
  parameter int TW = 7
);
  logic          tick;
  logic [0:7]    laneRequest;
  logic [TW-1:0] loadTime;
  logic [0:7]    normalGreen;
  logic [0:7]    green;
  logic [0:7]    yellow;
  logic [0:7]    red;
  logic          emergencyActive;
  logic [1:0]    grantPair;
  logic [TW-1:0] phaseTimer;

  // Driver of requests and schedule (encoder / scheduler / bench side)
  modport master (
    output tick, laneRequest, loadTime, normalGreen,
    input  green, yellow, red, emergencyActive, grantPair, phaseTimer
  );

  // The sequencer itself
  modport slave (
    input  tick, laneRequest, loadTime, normalGreen,
    output green, yellow, red, emergencyActive, grantPair, phaseTimer
  );
endinterface

// File: rtl/emergency_phase_sequencer.sv
// Emergency preemption of the light schedule: yellow-clear conflicting greens, hold granted pair, all-red, back to normal. Optional macro EMERGENCY_PREEMPT_EN lets a lower-index pair preempt during HOLD.
// Latency: all lamps and status are registered; lamps reflect the phase entered on the last edge (normal greens follow normalGreen by 1 cycle).
// Backpressure: none; requests are sampled only at arbitration points and ignored otherwise.
module emergency_phase_sequencer #(
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int TW           = 7
) (
  input  logic                   clk,
  input  logic                   resetN,
  emergency_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {NORMAL, CLEAR, HOLD, RECOVER} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [0:7]    snap, snap_nxt;
  logic [1:0]    grant, grant_nxt;

  logic [0:7]    green_q, yellow_q, red_q;
  logic          active_q;
  logic [0:7]    green_nxt, yellow_nxt, red_nxt;
  logic          active_nxt;
  logic [0:7]    lamp_mask;

  logic          any_req;
  logic [1:0]    win_pair;
  logic [TW-1:0] hold_load;
  logic          expire;
  logic          clear_short;
  logic [0:7]    grant_mask;
  logic          preempt;

  // Two adjacent lanes belonging to pair p
  function automatic logic [0:7] pair_mask(input logic [1:0] p);
    logic [0:7] m;
    m = '0;
    m[{p, 1'b0}] = 1'b1;
    m[{p, 1'b1}] = 1'b1;
    return m;
  endfunction

  // Lowest active pair wins; with no even lane set the result is 3, which can never preempt
  assign any_req  = |bus.laneRequest;
  assign win_pair = bus.laneRequest[0] ? 2'd0 :
                    bus.laneRequest[2] ? 2'd1 :
                    bus.laneRequest[4] ? 2'd2 : 2'd3;

  // A zero hold length still gives one tick of green
  assign hold_load   = (bus.loadTime == '0) ? TW'(1) : bus.loadTime;
  assign expire      = bus.tick && (timer == TW'(1));
  assign grant_mask  = pair_mask(grant);
  assign clear_short = ((snap & ~grant_mask) == '0);

`ifdef EMERGENCY_PREEMPT_EN
  assign preempt = (win_pair < grant);
`else
  assign preempt = 1'b0;
`endif

  // Next phase, countdown, snapshot and grant
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    snap_nxt  = snap;
    grant_nxt = grant;
    case (state)
      NORMAL: begin
        if (any_req) begin
          state_nxt = CLEAR;
          snap_nxt  = green_q;
          grant_nxt = win_pair;
          timer_nxt = TW'(YELLOW_TICKS);
        end
      end
      CLEAR: begin
        if (clear_short || expire) begin
          state_nxt = HOLD;
          timer_nxt = hold_load;
        end else if (bus.tick) begin
          timer_nxt = timer - TW'(1);
        end
      end
      HOLD: begin
        if (preempt) begin
          state_nxt = CLEAR;
          snap_nxt  = grant_mask;
          grant_nxt = win_pair;
          timer_nxt = TW'(YELLOW_TICKS);
        end else if (expire) begin
          if (bus.laneRequest[{grant, 1'b0}]) begin
            timer_nxt = hold_load;
          end else begin
            state_nxt = RECOVER;
            timer_nxt = TW'(ALLRED_TICKS);
          end
        end else if (bus.tick) begin
          timer_nxt = timer - TW'(1);
        end
      end
      RECOVER: begin
        if (expire) begin
          if (any_req) begin
            state_nxt = CLEAR;
            snap_nxt  = '0;
            grant_nxt = win_pair;
            timer_nxt = TW'(YELLOW_TICKS);
          end else begin
            state_nxt = NORMAL;
            timer_nxt = '0;
          end
        end else if (bus.tick) begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Lamp pattern of the phase being entered, so registered lamps match the current phase
  always_comb begin
    green_nxt  = '0;
    yellow_nxt = '0;
    red_nxt    = '1;
    lamp_mask  = pair_mask(grant_nxt);
    active_nxt = (state_nxt != NORMAL);
    case (state_nxt)
      NORMAL: begin
        green_nxt = bus.normalGreen;
        red_nxt   = ~bus.normalGreen;
      end
      CLEAR: begin
        green_nxt  = snap_nxt & lamp_mask;
        yellow_nxt = snap_nxt & ~lamp_mask;
        red_nxt    = ~snap_nxt;
      end
      HOLD: begin
        green_nxt = lamp_mask;
        red_nxt   = ~lamp_mask;
      end
      default: begin
        green_nxt  = '0;
        yellow_nxt = '0;
        red_nxt    = '1;
      end
    endcase
  end

  // State, timer and lamp registers; reset drops straight to all-red with no yellow
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= NORMAL;
      timer    <= '0;
      snap     <= '0;
      grant    <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      snap     <= snap_nxt;
      grant    <= grant_nxt;
      green_q  <= green_nxt;
      yellow_q <= yellow_nxt;
      red_q    <= red_nxt;
      active_q <= active_nxt;
    end
  end

  assign bus.green           = green_q;
  assign bus.yellow          = yellow_q;
  assign bus.red             = red_q;
  assign bus.emergencyActive = active_q;
  assign bus.grantPair       = grant;
  assign bus.phaseTimer      = timer;

endmodule

// File: tb/tb_emergency_phase_sequencer.sv
// Bench for emergency_phase_sequencer: directed scenarios plus random requests/ticks against a lane-level reference model.
// Latency: lamps are compared 1 time unit after every rising edge.
// Backpressure: none.
module tb_emergency_phase_sequencer;
  localparam int TW = 7;
  localparam int YT = 3;
  localparam int AT = 2;
`ifdef EMERGENCY_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam int PH_NORMAL  = 0;
  localparam int PH_CLEAR   = 1;
  localparam int PH_HOLD    = 2;
  localparam int PH_RECOVER = 3;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  emergency_phase_sequencer_if #(.TW(TW)) ifc ();

  emergency_phase_sequencer #(
    .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT),
    .TW(TW)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase, ticks left in phase, lanes shown, granted pair, lanes green at preemption
  int         m_ph;
  int         m_left;
  int         m_grant;
  logic [0:7] m_snap;
  logic [0:7] m_g, m_y, m_r;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lowest_pair(input logic [0:7] req);
    for (int p = 0; p < 4; p++)
      if (req[2*p]) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = PH_NORMAL; m_left = 0; m_grant = 0; m_snap = '0;
    m_g = '0; m_y = '0; m_r = '1;
  endtask

  // One clock of the specification's rules
  task automatic model_step(input bit t, input logic [0:7] req, input int lt, input logic [0:7] ng);
    int  hl;
    int  lp;
    bit  outside;
    bit  done;
    hl = (lt == 0) ? 1 : lt;
    lp = lowest_pair(req);
    done = t && (m_left == 1);
    outside = 1'b0;
    for (int i = 0; i < 8; i++)
      if (m_snap[i] && (i / 2 != m_grant)) outside = 1'b1;
    case (m_ph)
      PH_NORMAL: if (req != 0) begin
        m_snap = m_g; m_grant = (lp < 0) ? 3 : lp; m_ph = PH_CLEAR; m_left = YT;
      end
      PH_CLEAR: begin
        if (!outside || done) begin m_ph = PH_HOLD; m_left = hl; end
        else if (t) m_left--;
      end
      PH_HOLD: begin
        if (PREEMPT && lp >= 0 && lp < m_grant) begin
          m_snap = '0;
          m_snap[2*m_grant] = 1'b1; m_snap[2*m_grant+1] = 1'b1;
          m_grant = lp; m_ph = PH_CLEAR; m_left = YT;
        end else if (done) begin
          if (req[2*m_grant]) m_left = hl;
          else begin m_ph = PH_RECOVER; m_left = AT; end
        end else if (t) m_left--;
      end
      default: begin
        if (done) begin
          if (req != 0) begin m_ph = PH_CLEAR; m_snap = '0; m_grant = (lp < 0) ? 3 : lp; m_left = YT; end
          else begin m_ph = PH_NORMAL; m_left = 0; end
        end else if (t) m_left--;
      end
    endcase
    for (int i = 0; i < 8; i++) begin
      m_g[i] = 1'b0; m_y[i] = 1'b0; m_r[i] = 1'b0;
      case (m_ph)
        PH_NORMAL: begin m_g[i] = ng[i]; m_r[i] = !ng[i]; end
        PH_CLEAR: begin
          if (!m_snap[i]) m_r[i] = 1'b1;
          else if (i / 2 == m_grant) m_g[i] = 1'b1;
          else m_y[i] = 1'b1;
        end
        PH_HOLD: begin
          if (i / 2 == m_grant) m_g[i] = 1'b1; else m_r[i] = 1'b1;
        end
        default: m_r[i] = 1'b1;
      endcase
    end
  endtask

  task automatic compare_all();
    int ok;
    ok = 0;
    check_val("green", ifc.green, m_g);
    check_val("yellow", ifc.yellow, m_y);
    check_val("red", ifc.red, m_r);
    check_val("emergencyActive", ifc.emergencyActive, m_ph != PH_NORMAL);
    check_val("grantPair", ifc.grantPair, m_grant);
    check_val("phaseTimer", ifc.phaseTimer, m_left);
    for (int i = 0; i < 8; i++)
      if (int'(ifc.green[i]) + int'(ifc.yellow[i]) + int'(ifc.red[i]) == 1) ok++;
    check_val("one_lamp_per_lane", ok, 8);
  endtask

  task automatic step(input bit t, input logic [0:7] req, input logic [TW-1:0] lt, input logic [0:7] ng);
    @(negedge clk);
    ifc.tick = t; ifc.laneRequest = req; ifc.loadTime = lt; ifc.normalGreen = ng;
    @(posedge clk);
    model_step(t, req, int'(lt), ng);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input bit t, input logic [0:7] req, input logic [TW-1:0] lt, input logic [0:7] ng);
    for (int k = 0; k < n; k++) step(t, req, lt, ng);
  endtask

  task automatic wait_normal(input logic [0:7] ng);
    int n;
    n = 0;
    while (m_ph != PH_NORMAL && n < 300) begin
      step(1'b1, 8'h00, 7'd3, ng);
      n++;
    end
    step(1'b1, 8'h00, 7'd3, ng);
    check_val("reach_normal", ifc.emergencyActive, 1'b0);
  endtask

  function automatic logic [0:7] expand(input logic [3:0] pairs);
    logic [0:7] v;
    for (int p = 0; p < 4; p++) begin
      v[2*p] = pairs[p]; v[2*p+1] = pairs[p];
    end
    return v;
  endfunction

  initial begin
    logic [3:0]    cur_pairs;
    int            hold_cnt;
    logic [TW-1:0] cur_lt;
    logic [0:7]    cur_ng;
    bit            tick_all;
    int            n;

    resetN = 1'b0;
    ifc.tick = 1'b0; ifc.laneRequest = '0; ifc.loadTime = '0; ifc.normalGreen = '0;
    model_reset();
    @(posedge clk); #1;
    check_val("rst_green", ifc.green, 8'h00);
    check_val("rst_yellow", ifc.yellow, 8'h00);
    check_val("rst_red", ifc.red, 8'hFF);
    check_val("rst_active", ifc.emergencyActive, 1'b0);
    check_val("rst_grant", ifc.grantPair, 2'd0);
    check_val("rst_timer", ifc.phaseTimer, 7'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Normal schedule passes through with one cycle of latency
    run(2, 1'b1, 8'h00, 7'd3, 8'hC0);
    check_val("normal_green_C0", ifc.green, 8'hC0);
    check_val("normal_red_3F", ifc.red, 8'h3F);

    // Single short request: yellow clear, hold, all-red, back to normal
    run(1, 1'b1, 8'h0C, 7'd3, 8'hC0);
    check_val("clear_yellow_C0", ifc.yellow, 8'hC0);
    wait_normal(8'hC0);

    // Two pairs requesting at once
    run(1, 1'b1, 8'h33, 7'd3, 8'hC0);
    wait_normal(8'hC0);

    // Held request extends HOLD
    run(7, 1'b1, 8'h03, 7'd3, 8'hC0);
    wait_normal(8'hC0);

    // Zero hold length with nothing to clear
    run(2, 1'b1, 8'h00, 7'd0, 8'h00);
    run(1, 1'b1, 8'hC0, 7'd0, 8'h00);
    wait_normal(8'h00);

    // Sparse ticks freeze the countdown
    run(1, 1'b1, 8'h0C, 7'd3, 8'hC0);
    run(5, 1'b0, 8'h00, 7'd3, 8'hC0);
    wait_normal(8'hC0);

    // Request from another pair waiting through RECOVER re-enters CLEAR
    run(1, 1'b1, 8'h30, 7'd1, 8'hFF);
    run(4, 1'b1, 8'h00, 7'd1, 8'hFF);
    run(6, 1'b1, 8'h03, 7'd1, 8'hFF);
    wait_normal(8'hFF);

    // Higher-priority pair during HOLD of pair 3
    run(1, 1'b1, 8'h03, 7'd6, 8'h00);
    run(2, 1'b1, 8'h03, 7'd6, 8'h00);
    run(6, 1'b1, 8'hC3, 7'd6, 8'h00);
    wait_normal(8'h00);

    // Asynchronous reset in the middle of HOLD
    step(1'b1, 8'h03, 7'd5, 8'h00);
    n = 0;
    while (m_ph != PH_HOLD && n < 10) begin
      step(1'b1, 8'h03, 7'd5, 8'h00);
      n++;
    end
    check_val("hold_reached", ifc.emergencyActive, 1'b1);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check_val("async_rst_red", ifc.red, 8'hFF);
    check_val("async_rst_green", ifc.green, 8'h00);
    check_val("async_rst_active", ifc.emergencyActive, 1'b0);
    check_val("async_rst_timer", ifc.phaseTimer, 7'd0);
    model_reset();
    @(negedge clk);
    ifc.laneRequest = '0;
    resetN = 1'b1;

    // Random traffic
    cur_pairs = '0; hold_cnt = 0; cur_lt = 7'd3; cur_ng = 8'h00; tick_all = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) tick_all = $urandom_range(0, 1) == 1;
      if (hold_cnt == 0) begin
        cur_pairs = ($urandom_range(0, 9) < 6) ? 4'h0 : 4'($urandom_range(1, 15));
        hold_cnt  = $urandom_range(1, 12);
      end
      hold_cnt--;
      if ($urandom_range(0, 9) == 0) cur_lt = ($urandom_range(0, 9) == 0) ? TW'($urandom_range(7, 20)) : TW'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) cur_ng = 8'($urandom);
      step(tick_all ? 1'b1 : ($urandom_range(0, 1) == 1), expand(cur_pairs), cur_lt, cur_ng);
    end
    wait_normal(8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
